// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/flush controller: per-stage write enables, flushes and cache controls from freeze/exception/stall/redirect requests.
// Latency: outputs are combinational in the current inputs and state; state (pending exception, store tracker, counters) updates on clk.
// Backpressure: mem_busy/if_busy freeze every stage; load-vs-store line conflicts and stall_req hold the younger stages.
// Ports: clk, resetn (sync, active low); request inputs mem_busy/if_busy/exc_flush/stall_req/redir_req;
//        the memory op at LD_STAGE (ls_*); outputs stage_wr/stage_flush/wr_disable, I/D cache controls,
//        and the saturating stall_cnt/redir_cnt counters.
module pipe_hazard_ctrl #(
   parameter int N_STAGE    = 7,
   parameter int LD_STAGE   = 4,
   parameter int EXC_STAGE  = 4,
   parameter int ST_DEPTH   = 2,
   parameter int LINE_OFS_W = 5,
   parameter int CNT_W      = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               mem_busy,
   input  logic               if_busy,
   input  logic               exc_flush,
   input  logic [N_STAGE-1:0] stall_req,
   input  logic [N_STAGE-1:0] redir_req,
   input  logic               ls_valid,
   input  logic               ls_is_store,
   input  logic               ls_cached,
   input  logic [31:0]        ls_addr,
   output logic [N_STAGE-1:0] stage_wr,
   output logic [N_STAGE-1:0] stage_flush,
   output logic [N_STAGE-1:0] wr_disable,
   output logic               icache_flush,
   output logic               ireq_valid,
   output logic               dreq_valid,
   output logic               icache_stall,
   output logic               dcache_stall,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   redir_cnt
);

   localparam int LINE_W = 32 - LINE_OFS_W;
   localparam int KW     = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic                exc_pend;
   logic [ST_DEPTH-1:0] st_v;
   logic [LINE_W-1:0]   st_line [ST_DEPTH];

   logic [LINE_W-1:0]   ls_line;
   logic                ld_conflict;
   logic [KW-1:0]       stall_k;
   logic [KW-1:0]       redir_k;
   logic                exc_row;
   logic                ldc_row;
   logic                redir_row;
   logic                st_new_v;

   // Offset bits within a line never take part in the store/load compare.
   logic unused_ofs;
   assign unused_ofs = ^ls_addr[LINE_OFS_W-1:0];

   assign ls_line = ls_addr[31:LINE_OFS_W];

   // A cached load hits a line still being written by an older in-flight store.
   always_comb begin
      ld_conflict = 1'b0;
      for (int i = 0; i < ST_DEPTH; i++) begin
         if (st_v[i] && (st_line[i] == ls_line)) ld_conflict = 1'b1;
      end
      ld_conflict = ld_conflict & ls_valid & ~ls_is_store & ls_cached;
   end

   // Oldest (highest-index) requester wins for both stalls and redirects.
   always_comb begin
      stall_k = '0;
      redir_k = '0;
      for (int i = 0; i < N_STAGE; i++) begin
         if (stall_req[i]) stall_k = i[KW-1:0];
         if (redir_req[i]) redir_k = i[KW-1:0];
      end
   end

   always_comb begin
      stage_wr     = '1;
      stage_flush  = '0;
      wr_disable   = '0;
      icache_flush = 1'b0;
      ireq_valid   = 1'b1;
      dreq_valid   = 1'b1;
      icache_stall = 1'b0;
      dcache_stall = 1'b0;
      exc_row      = 1'b0;
      ldc_row      = 1'b0;
      redir_row    = 1'b0;
      if (!resetn) begin
         stage_wr     = '0;
         stage_flush  = '1;
         wr_disable   = '1;
         icache_flush = 1'b1;
         ireq_valid   = 1'b0;
         dreq_valid   = 1'b0;
      end else if (mem_busy) begin
         stage_wr = '0;
         for (int i = 0; i < N_STAGE; i++) wr_disable[i] = (i >= LD_STAGE);
         dreq_valid   = 1'b0;
         icache_stall = 1'b1;
         dcache_stall = 1'b1;
      end else if (exc_flush || exc_pend) begin
         // A redirect in the same cycle is dropped: the exception owns the PC.
         exc_row = 1'b1;
         for (int i = 0; i < N_STAGE; i++) begin
            stage_flush[i] = (i <= EXC_STAGE);
            wr_disable[i]  = (i >= 1) && (i <= EXC_STAGE);
         end
         icache_flush = 1'b1;
         ireq_valid   = 1'b0;
         dreq_valid   = 1'b0;
      end else if (if_busy) begin
         stage_wr = '0;
         for (int i = 0; i < N_STAGE; i++) wr_disable[i] = (i >= LD_STAGE);
         ireq_valid   = 1'b0;
         icache_stall = 1'b1;
         dcache_stall = 1'b1;
      end else if (ld_conflict) begin
         // Older stages keep draining so the conflicting store moves out of the way.
         ldc_row = 1'b1;
         for (int i = 0; i < N_STAGE; i++) begin
            stage_wr[i]    = (i > LD_STAGE);
            stage_flush[i] = (i == LD_STAGE + 1);
         end
         ireq_valid   = 1'b0;
         dreq_valid   = 1'b0;
         icache_stall = 1'b1;
      end else if (|stall_req) begin
         for (int i = 0; i < N_STAGE; i++) begin
            stage_wr[i]    = (i > int'(stall_k));
            stage_flush[i] = (i == int'(stall_k) + 1);
            wr_disable[i]  = (i == int'(stall_k)) && (int'(stall_k) > LD_STAGE);
         end
         icache_stall = 1'b1;
      end else if (|redir_req) begin
         redir_row = 1'b1;
         for (int i = 0; i < N_STAGE; i++) stage_flush[i] = (i >= 1) && (i < int'(redir_k));
         icache_flush = 1'b1;
         ireq_valid   = 1'b0;
      end
   end

   assign st_new_v = ~ldc_row & ls_valid & ls_is_store & ls_cached & ~stage_flush[LD_STAGE+1];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         exc_pend  <= 1'b0;
         st_v      <= '0;
         stall_cnt <= '0;
         redir_cnt <= '0;
         for (int i = 0; i < ST_DEPTH; i++) st_line[i] <= '0;
      end else begin
         // Exceptions arriving under a memory freeze are replayed once it lifts.
         if (mem_busy) begin
            if (exc_flush) exc_pend <= 1'b1;
         end else if (exc_row) begin
            exc_pend <= 1'b0;
         end

         // Tracker entry i mirrors the store sitting at stage LD_STAGE+1+i.
         if (stage_wr[LD_STAGE+1]) begin
            st_v[0]    <= st_new_v;
            st_line[0] <= ls_line;
            for (int i = 1; i < ST_DEPTH; i++) begin
               st_v[i]    <= st_v[i-1];
               st_line[i] <= st_line[i-1];
            end
         end
         if (exc_row) begin
            for (int i = 0; i < ST_DEPTH; i++) begin
               if (LD_STAGE + 1 + i <= EXC_STAGE) st_v[i] <= 1'b0;
            end
         end

         if (!stage_wr[0] && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
         if ((exc_row || redir_row) && (redir_cnt != '1)) redir_cnt <= redir_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by randomized traffic against a reference model.
// Latency: outputs compared on the falling edge each cycle; model state advances on the rising edge.
// Backpressure: freezes, conflicts and stalls are exercised via random request mixes.
module tb_pipe_hazard_ctrl;

   localparam int N   = 7;
   localparam int LD  = 4;
   localparam int EXC = 4;
   localparam int SD  = 2;
   localparam int OFS = 5;
   localparam int CW  = 32;
   localparam longint CMAX = (64'd1 << CW) - 1;

   logic          clk = 1'b0;
   logic          resetn, mem_busy, if_busy, exc_flush;
   logic [N-1:0]  stall_req, redir_req;
   logic          ls_valid, ls_is_store, ls_cached;
   logic [31:0]   ls_addr;
   logic [N-1:0]  stage_wr, stage_flush, wr_disable;
   logic          icache_flush, ireq_valid, dreq_valid, icache_stall, dcache_stall;
   logic [CW-1:0] stall_cnt, redir_cnt;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .N_STAGE(N), .LD_STAGE(LD), .EXC_STAGE(EXC), .ST_DEPTH(SD), .LINE_OFS_W(OFS), .CNT_W(CW)
   ) dut (
      .clk(clk), .resetn(resetn), .mem_busy(mem_busy), .if_busy(if_busy), .exc_flush(exc_flush),
      .stall_req(stall_req), .redir_req(redir_req), .ls_valid(ls_valid), .ls_is_store(ls_is_store),
      .ls_cached(ls_cached), .ls_addr(ls_addr), .stage_wr(stage_wr), .stage_flush(stage_flush),
      .wr_disable(wr_disable), .icache_flush(icache_flush), .ireq_valid(ireq_valid),
      .dreq_valid(dreq_valid), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
      .stall_cnt(stall_cnt), .redir_cnt(redir_cnt)
   );

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // Reference model state: pending exception, in-flight store lines, counters.
   bit          m_pend;
   bit          m_v    [SD];
   int unsigned m_line [SD];
   longint      m_stall, m_redir;

   // Expected outputs and the priority row that produced them.
   int e_wr, e_flush, e_wd, e_row;
   bit e_if, e_ireq, e_dreq, e_is, e_ds;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int top_idx(input logic [N-1:0] v);
      int k = -1;
      for (int i = 0; i < N; i++) if (v[i]) k = i;
      return k;
   endfunction

   task automatic model_eval();
      int all = (1 << N) - 1;
      int k;
      bit conf = 0;
      for (int i = 0; i < SD; i++)
         if (m_v[i] && m_line[i] == (ls_addr >> OFS)) conf = 1;
      conf = conf && ls_valid && !ls_is_store && ls_cached;
      e_wr = all; e_flush = 0; e_wd = 0; e_if = 0; e_ireq = 1; e_dreq = 1; e_is = 0; e_ds = 0; e_row = 7;
      if (!resetn) begin
         e_row = 0; e_wr = 0; e_flush = all; e_wd = all; e_if = 1; e_ireq = 0; e_dreq = 0;
      end else if (mem_busy) begin
         e_row = 1; e_wr = 0; e_wd = all & ~((1 << LD) - 1); e_dreq = 0; e_is = 1; e_ds = 1;
      end else if (exc_flush || m_pend) begin
         e_row = 2; e_flush = (1 << (EXC + 1)) - 1; e_wd = e_flush & ~1; e_if = 1; e_ireq = 0; e_dreq = 0;
      end else if (if_busy) begin
         e_row = 3; e_wr = 0; e_wd = all & ~((1 << LD) - 1); e_ireq = 0; e_is = 1; e_ds = 1;
      end else if (conf) begin
         e_row = 4; e_wr = all & ~((1 << (LD + 1)) - 1); e_flush = 1 << (LD + 1);
         e_ireq = 0; e_dreq = 0; e_is = 1;
      end else if (stall_req != 0) begin
         k = top_idx(stall_req);
         e_row = 5; e_wr = all & ~((1 << (k + 1)) - 1);
         e_flush = (k + 1 < N) ? (1 << (k + 1)) : 0;
         e_wd = (k > LD) ? (1 << k) : 0;
         e_is = 1;
      end else if (redir_req != 0) begin
         k = top_idx(redir_req);
         e_row = 6; e_flush = (k <= 1) ? 0 : (((1 << k) - 1) & ~1); e_if = 1; e_ireq = 0;
      end
   endtask

   task automatic model_update();
      if (!resetn) begin
         m_pend = 0; m_stall = 0; m_redir = 0;
         for (int i = 0; i < SD; i++) begin m_v[i] = 0; m_line[i] = 0; end
         return;
      end
      if (e_row == 1 && exc_flush) m_pend = 1;
      else if (e_row == 2) m_pend = 0;
      if (((e_wr >> (LD + 1)) & 1) == 1) begin
         for (int i = SD - 1; i >= 1; i--) begin m_v[i] = m_v[i-1]; m_line[i] = m_line[i-1]; end
         m_v[0]    = (e_row != 4) && ls_valid && ls_is_store && ls_cached && (((e_flush >> (LD + 1)) & 1) == 0);
         m_line[0] = ls_addr >> OFS;
      end
      if (e_row == 2)
         for (int i = 0; i < SD; i++) if (LD + 1 + i <= EXC) m_v[i] = 0;
      if ((e_wr & 1) == 0 && m_stall < CMAX) m_stall++;
      if ((e_row == 2 || e_row == 6) && m_redir < CMAX) m_redir++;
   endtask

   // One clock: compare everything against the model mid-cycle, then advance the model.
   task automatic cyc();
      @(negedge clk);
      model_eval();
      chk("stage_wr",     64'(stage_wr),     64'(e_wr));
      chk("stage_flush",  64'(stage_flush),  64'(e_flush));
      chk("wr_disable",   64'(wr_disable),   64'(e_wd));
      chk("cache_ctrl",   64'({icache_flush, ireq_valid, dreq_valid, icache_stall, dcache_stall}),
                          64'({e_if, e_ireq, e_dreq, e_is, e_ds}));
      chk("stall_cnt",    64'(stall_cnt),    64'(m_stall));
      chk("redir_cnt",    64'(redir_cnt),    64'(m_redir));
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_in();
      resetn = 1; mem_busy = 0; if_busy = 0; exc_flush = 0; stall_req = '0; redir_req = '0;
      ls_valid = 0; ls_is_store = 0; ls_cached = 0; ls_addr = '0;
   endtask

   task automatic mem_op(input bit store, input logic [31:0] addr);
      ls_valid = 1; ls_is_store = store; ls_cached = 1; ls_addr = addr;
   endtask

   initial begin
      idle_in();
      resetn = 0;
      m_pend = 0; m_stall = 0; m_redir = 0;
      for (int i = 0; i < SD; i++) begin m_v[i] = 0; m_line[i] = 0; end
      #1;
      chk("rst_wr", 64'(stage_wr), 64'h0);
      chk("rst_flush", 64'(stage_flush), 64'h7F);
      cyc(); cyc();

      // Idle pipe: everything writes, no stall counted.
      resetn = 1;
      #1 chk("idle_wr", 64'(stage_wr), 64'h7F);
      chk("idle_req", 64'({ireq_valid, dreq_valid}), 64'h3);
      cyc(); cyc(); cyc();
      chk("idle_stall_cnt", 64'(stall_cnt), 64'h0);

      // Store then load to the same line: two conflict cycles.
      mem_op(1, 32'h8000_0010); cyc();
      mem_op(0, 32'h8000_001C);
      #1 chk("ldc1_wr", 64'(stage_wr), 64'h60);
      chk("ldc1_flush", 64'(stage_flush), 64'h20);
      cyc();
      #1 chk("ldc2_wr", 64'(stage_wr), 64'h60);
      cyc();
      #1 chk("ldc_done_wr", 64'(stage_wr), 64'h7F);
      chk("ldc_stall_cnt", 64'(stall_cnt), 64'd2);
      cyc();
      // Next line over: no conflict.
      mem_op(1, 32'h8000_0010); cyc();
      mem_op(0, 32'h8000_0020);
      #1 chk("noconf_wr", 64'(stage_wr), 64'h7F);
      cyc();
      idle_in(); cyc(); cyc();

      // Exception during memory freeze is replayed after it lifts.
      mem_busy = 1; cyc();
      exc_flush = 1;
      #1 chk("frz_wr", 64'(stage_wr), 64'h0);
      cyc();
      exc_flush = 0; cyc();
      mem_busy = 0;
      #1 chk("replay_flush", 64'(stage_flush), 64'h1F);
      chk("replay_iflush", 64'(icache_flush), 64'h1);
      cyc();
      chk("replay_redir_cnt", 64'(redir_cnt), 64'd1);
      cyc();

      // Two stall requesters: the oldest (stage 4) wins.
      stall_req = 7'b0010100;
      #1 chk("stall4_wr", 64'(stage_wr), 64'h60);
      chk("stall4_flush", 64'(stage_flush), 64'h20);
      chk("stall4_wd", 64'(wr_disable), 64'h0);
      cyc();
      stall_req = '0;

      // Exception beats a simultaneous redirect; counted once.
      redir_req = 7'b0001000; exc_flush = 1;
      #1 chk("excredir_flush", 64'(stage_flush), 64'h1F);
      cyc();
      idle_in();
      chk("excredir_cnt", 64'(redir_cnt), 64'd2);
      cyc();

      // Reset in the middle of a conflict stall clears everything.
      mem_op(1, 32'h8000_0040); cyc();
      mem_op(0, 32'h8000_0044);
      #1 chk("pre_rst_wr", 64'(stage_wr), 64'h60);
      resetn = 0; cyc();
      resetn = 1;
      #1 chk("post_rst_wr", 64'(stage_wr), 64'h7F);
      chk("post_rst_scnt", 64'(stall_cnt), 64'h0);
      chk("post_rst_rcnt", 64'(redir_cnt), 64'h0);
      cyc();
      idle_in(); cyc();

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         resetn      = ($urandom_range(0, 79) != 0);
         mem_busy    = ($urandom_range(0, 9) == 0);
         if_busy     = ($urandom_range(0, 11) == 0);
         exc_flush   = ($urandom_range(0, 15) == 0);
         stall_req   = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
         redir_req   = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
         ls_valid    = ($urandom_range(0, 3) != 0);
         ls_is_store = ($urandom_range(0, 1) == 0);
         ls_cached   = ($urandom_range(0, 7) != 0);
         ls_addr     = 32'h8000_0000 | (32'($urandom_range(0, 3)) << OFS) | 32'($urandom_range(0, 31));
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
